eeprom_slave: RTL
=================

Name: eeprom_slave

Overview:
- Serial EEPROM responder: the device end of the team's 2-wire EEPROM bus, complementing the existing bus master.
- Decodes START/STOP, control byte, 11-bit address and data from SCL/SDA.
- Stores bytes in an internal 2048x8 array and serialises read data back onto SDA.
- Used as the synthesizable memory model in system benches and FPGA loopback builds.

Parameters:
- ADDR_W, 11, byte address width: A10..A8 carried in the control byte, A7..A0 in the address byte.
- DEV_CODE, 4'b1010, device type code expected in control byte bits 7..4.
- MEM_DEPTH, 2048, number of bytes stored; must equal 2**ADDR_W.
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA before edge detection.

Ports:
- CLK, input, 1, sampling clock; must be at least 8x the SCL frequency.
- RESET, input, 1, synchronous active-high reset.
- SCL, input, 1, serial clock from the master.
- SDA, inout, 1, serial data; driven only while the slave returns read bits (or ACK), otherwise 1'bz.
- BUSY, output, 1, high from START detection until STOP detection.
- WR_DONE, output, 1, one-CLK pulse when a write byte is committed to memory.
- RD_DONE, output, 1, one-CLK pulse after the 8th read bit is released.
- ERR, output, 1, one-CLK pulse on device code mismatch or STOP during an incomplete byte.

Behaviour:
- Reset:
  - SDA is z; BUSY, WR_DONE, RD_DONE and ERR are 0; state is IDLE.
  - Shift register, bit counter and address register are 0.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts immediately with no memory write.
- Synchronisation and edge detection:
  - SCL and SDA pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Bit sample = SCL rising. Slave drive update = SCL falling.
  - Event-to-action latency is SYNC_STAGES+1 CLK.
- Framing:
  - Bytes are MSB first, 8 bits, no ACK slot (default build).
  - Write: START, ctrl {DEV_CODE, A10..A8, 0}, addr[7:0], data[7:0], STOP.
  - Random read: START, ctrl W, addr, repeated START, ctrl {DEV_CODE, A10..A8, 1}, 8 slave-driven bits, STOP.
- State machine and transitions:
  - IDLE -> CTRL on START.
  - CTRL: after 8 bits:
    - Code mismatch: pulse ERR, go to WAIT_STOP.
    - R/W=0: latch A10..A8, go to ADDR.
    - R/W=1: load mem[addr], go to RDATA.
  - ADDR: after 8 bits, latch A7..A0, go to WDATA.
  - WDATA:
    - 8 bits received: hold the byte, go to WAIT_STOP with write pending.
    - START during WDATA before any bit is received: treated as a repeated START, go to CTRL with the address retained.
  - RDATA:
    - Drive bit7 on SDA at the first SCL falling edge after ctrl completes.
    - Shift one bit per SCL falling edge.
    - Release SDA (z) at the falling edge after bit0, pulse RD_DONE, go to WAIT_STOP.
  - WAIT_STOP: ignore SCL; on STOP, commit any pending write (WR_DONE pulse, same CLK as STOP detection), go to IDLE.
- Global overrides:
  - START in any state -> CTRL; any pending write is discarded.
  - STOP in any state -> IDLE.
  - STOP with a partial byte (1..7 bits) pulses ERR and writes nothing.
- Address rules:
  - Address wraps modulo MEM_DEPTH.
  - No auto-increment; each transaction addresses one byte.
- Simultaneous events: a START/STOP detected in the same CLK as an SCL edge takes priority.
- SDA drive: the slave drives actual 0/1 values (not open-drain) while in RDATA, and only in RDATA.

Optional Feature:
- Macro: EEPROM_SLAVE_ACK_SLOT_EN.
- Defined:
  - Every byte has a 9th SCL clock.
  - After ctrl (matching code), addr and write-data bytes, the slave drives SDA=0 from the falling edge after bit0 to the next falling edge.
  - A mismatched ctrl byte gets no ACK (z).
  - After a read byte the slave releases SDA and samples the master ACK/NACK; the sampled value is ignored.
- Undefined: 8-clock bytes with no ACK logic, as described in Behaviour.

Decomposition:
- Package eeprom_pkg:
  - State encoding (IDLE, CTRL, ADDR, WDATA, RDATA, WAIT_STOP).
  - DEV_CODE, R/W bit position and ADDR_W defaults.
  - Shared with the master so both ends use the same constants.
- Sub-module eeprom_bus_sync:
  - Synchronisers, edge detect, and START/STOP/scl_rise/scl_fall pulse outputs.
  - Keeps the FSM purely event-driven.

Test Plan:
- Write 8'hA5 to address 11'h123 (ctrl 8'hA2, addr 8'h23), then STOP -> WR_DONE pulses once; mem[11'h123]=8'hA5.
- Random read of 11'h123 (ctrl 8'hA2, addr 8'h23, repeated START, ctrl 8'hA3) -> SDA shows 1,0,1,0,0,1,0,1 on SCL highs; RD_DONE pulses; SDA is z afterwards.
- Ctrl byte 8'hB2 (wrong code) -> ERR pulse, SDA stays z, following data ignored, memory unchanged.
- STOP after 5 data bits -> ERR pulse, no WR_DONE, previous memory value retained.
- RESET asserted mid-RDATA -> next CLK SDA is z, BUSY=0, state IDLE; a new write then succeeds.
- With EEPROM_SLAVE_ACK_SLOT_EN, write 8'h3C to 11'h7FF -> SDA=0 during the 9th clock of each of the three bytes; mem[11'h7FF]=8'h3C.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Constants and state encoding shared by both ends of the 2-wire EEPROM bus.
package eeprom_pkg;

  localparam int         DEF_ADDR_W      = 11;
  localparam int         DEF_MEM_DEPTH   = 2048;
  localparam int         DEF_SYNC_STAGES = 2;
  localparam logic [3:0] DEF_DEV_CODE    = 4'b1010;
  localparam int         RW_BIT          = 0;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    ADDR,
    WDATA,
    RDATA,
    WAIT_STOP
  } state_t;

  function automatic logic dev_match(input logic [7:0] ctrl, input logic [3:0] code);
    return ctrl[7:4] == code;
  endfunction

endpackage

// File: rtl/eeprom_bus_sync.sv
// Synchronises SCL/SDA into CLK and turns bus transitions into one-CLK event pulses.
module eeprom_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  input  logic SDA_IN,
  output logic sda_s,
  output logic start_evt,
  output logic stop_evt,
  output logic scl_rise,
  output logic scl_fall
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_s;

  // Flops reset to 1 so an idle bus after reset never looks like a START.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge CLK) begin
        if (RESET) begin
          scl_sync_reg[gi] <= 1'b1;
          sda_sync_reg[gi] <= 1'b1;
        end else if (gi == 0) begin
          scl_sync_reg[gi] <= SCL;
          sda_sync_reg[gi] <= SDA_IN;
        end else begin
          scl_sync_reg[gi] <= scl_sync_reg[gi-1];
          sda_sync_reg[gi] <= sda_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_s;
      sda_d_reg <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign start_evt = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_evt  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;

endmodule

// File: rtl/eeprom_slave.sv
// Device end of the 2-wire EEPROM bus with a 2048x8 byte store.
// Define EEPROM_SLAVE_ACK_SLOT_EN to add a 9th ACK clock to every byte.
module eeprom_slave
  import eeprom_pkg::*;
#(
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter logic [3:0] DEV_CODE    = DEF_DEV_CODE,
  parameter int         MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  inout  wire  SDA,
  output logic BUSY,
  output logic WR_DONE,
  output logic RD_DONE,
  output logic ERR
);

  state_t              state_reg;
  logic [7:0]          shift_reg;
  logic [3:0]          bit_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wr_pending_reg;
  logic                sda_oe_reg;
  logic                sda_out_reg;
  logic [7:0]          rd_data_reg;
  logic [7:0]          mem [MEM_DEPTH];

  logic sda_s, start_evt, stop_evt, scl_rise, scl_fall;
  logic [7:0] byte_in;
  logic mem_we, rx_skip, rd_go;

  eeprom_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .SCL       (SCL),
    .SDA_IN    (SDA),
    .sda_s     (sda_s),
    .start_evt (start_evt),
    .stop_evt  (stop_evt),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall)
  );

  assign SDA     = sda_oe_reg ? sda_out_reg : 1'bz;
  assign byte_in = {shift_reg[6:0], sda_s};
  assign mem_we  = !RESET && stop_evt && (state_reg == WAIT_STOP) && wr_pending_reg;

`ifdef EEPROM_SLAVE_ACK_SLOT_EN
  logic ack_req_reg;
  logic ack_drv_reg;
  // The ACK clock's rising edge must not be shifted in as a data bit.
  assign rx_skip = ack_drv_reg;
  assign rd_go   = !ack_req_reg;
`else
  assign rx_skip = 1'b0;
  assign rd_go   = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_reg] <= shift_reg;
    rd_data_reg <= mem[addr_reg];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      addr_reg       <= '0;
      wr_pending_reg <= 1'b0;
      sda_oe_reg     <= 1'b0;
      sda_out_reg    <= 1'b0;
      BUSY           <= 1'b0;
      WR_DONE        <= 1'b0;
      RD_DONE        <= 1'b0;
      ERR            <= 1'b0;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
      ack_req_reg    <= 1'b0;
      ack_drv_reg    <= 1'b0;
`endif
    end else begin
      WR_DONE <= 1'b0;
      RD_DONE <= 1'b0;
      ERR     <= 1'b0;
      if (start_evt) begin
        state_reg      <= CTRL;
        shift_reg      <= '0;
        bit_cnt_reg    <= '0;
        wr_pending_reg <= 1'b0;
        sda_oe_reg     <= 1'b0;
        BUSY           <= 1'b1;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
        ack_req_reg    <= 1'b0;
        ack_drv_reg    <= 1'b0;
`endif
      end else if (stop_evt) begin
        if ((state_reg == CTRL || state_reg == ADDR || state_reg == WDATA) && bit_cnt_reg != 4'd0)
          ERR <= 1'b1;
        if (state_reg == WAIT_STOP && wr_pending_reg)
          WR_DONE <= 1'b1;
        state_reg      <= IDLE;
        bit_cnt_reg    <= '0;
        wr_pending_reg <= 1'b0;
        sda_oe_reg     <= 1'b0;
        BUSY           <= 1'b0;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
        ack_req_reg    <= 1'b0;
        ack_drv_reg    <= 1'b0;
`endif
      end else begin
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
        if (scl_fall && ack_req_reg) begin
          ack_req_reg <= 1'b0;
          ack_drv_reg <= 1'b1;
          sda_oe_reg  <= 1'b1;
          sda_out_reg <= 1'b0;
        end else if (scl_fall && ack_drv_reg && state_reg != RDATA) begin
          ack_drv_reg <= 1'b0;
          sda_oe_reg  <= 1'b0;
        end
`endif
        case (state_reg)
          CTRL, ADDR, WDATA: begin
            if (scl_rise && !rx_skip) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                bit_cnt_reg <= '0;
                if (state_reg == CTRL) begin
                  if (!dev_match(byte_in, DEV_CODE)) begin
                    ERR       <= 1'b1;
                    state_reg <= WAIT_STOP;
                  end else begin
                    addr_reg[ADDR_W-1:8] <= byte_in[ADDR_W-8:1];
                    state_reg <= byte_in[RW_BIT] ? RDATA : ADDR;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
                    ack_req_reg <= 1'b1;
`endif
                  end
                end else if (state_reg == ADDR) begin
                  addr_reg[7:0] <= byte_in;
                  state_reg     <= WDATA;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
                  ack_req_reg   <= 1'b1;
`endif
                end else begin
                  wr_pending_reg <= 1'b1;
                  state_reg      <= WAIT_STOP;
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
                  ack_req_reg    <= 1'b1;
`endif
                end
              end
            end
          end
          RDATA: begin
            // bit_cnt counts bits already driven; the 9th falling edge releases SDA.
            if (scl_fall && rd_go) begin
`ifdef EEPROM_SLAVE_ACK_SLOT_EN
              ack_drv_reg <= 1'b0;
`endif
              if (bit_cnt_reg == 4'd8) begin
                sda_oe_reg  <= 1'b0;
                RD_DONE     <= 1'b1;
                bit_cnt_reg <= '0;
                state_reg   <= WAIT_STOP;
              end else begin
                sda_oe_reg  <= 1'b1;
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd0) begin
                  sda_out_reg <= rd_data_reg[7];
                  shift_reg   <= {rd_data_reg[6:0], 1'b0};
                end else begin
                  sda_out_reg <= shift_reg[7];
                  shift_reg   <= {shift_reg[6:0], 1'b0};
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
